// File: rtl/self_attention_sched_if.sv
// Handshake bundle between the attention tile scheduler and its B2R / softmax / R2B neighbours.
// SELF_ATTN_SCHED_STALL_CNT_EN adds the 16-bit stall_cnt observation output.
interface self_attention_sched_if #(
    parameter int NUM_LANES = 4,
    parameter int NUM_TILES = 8,
    parameter int NUM_HEADS = 2
);
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;

    logic                 start;
    logic                 b2r_valid;
    logic                 b2r_ready;
    logic                 b2r_slice_done;
    logic                 b2r_clr;
    logic                 sm_en;
    logic [NUM_LANES-1:0] sm_valid;
    logic [TW-1:0]        sm_tile_idx;
    logic [NUM_LANES-1:0] sm_done;
    logic [NUM_LANES-1:0] sm_clr;
    logic [NUM_LANES-1:0] r2b_valid;
    logic                 r2b_ready;
    logic [HW-1:0]        head_idx;
    logic                 busy;
    logic                 done;
`ifdef SELF_ATTN_SCHED_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    // master: the scheduler side
    modport master (
        input  start, b2r_valid, b2r_slice_done, sm_done, r2b_ready,
        output b2r_ready, b2r_clr, sm_en, sm_valid, sm_tile_idx, sm_clr,
               r2b_valid, head_idx, busy, done
`ifdef SELF_ATTN_SCHED_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output start, b2r_valid, b2r_slice_done, sm_done, r2b_ready,
        input  b2r_ready, b2r_clr, sm_en, sm_valid, sm_tile_idx, sm_clr,
               r2b_valid, head_idx, busy, done
`ifdef SELF_ATTN_SCHED_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/self_attention_sched.sv
// Self-attention tile scheduler: round-robin tile issue to softmax lanes, completion tracking, R2B drain.
// SELF_ATTN_SCHED_STALL_CNT_EN adds a saturating stall counter on bus.stall_cnt.

// Sticky per-lane softmax completion flag; a clear beats a simultaneous done.
module sched_lane_done (
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic clr,
    output logic mask
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       mask <= 1'b0;
        else if (clr)  mask <= 1'b0;
        else if (done) mask <= 1'b1;
    end
endmodule

module self_attention_sched #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_TILES  = 8,
    parameter int ROW_GROUPS = 2,
    parameter int NUM_HEADS  = 2
) (
    input logic                    clk,
    input logic                    rst,
    self_attention_sched_if.master bus
);
    localparam int LW = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1;
    localparam int TW = (NUM_TILES  > 1) ? $clog2(NUM_TILES)  : 1;
    localparam int GW = (ROW_GROUPS > 1) ? $clog2(ROW_GROUPS) : 1;
    localparam int HW = (NUM_HEADS  > 1) ? $clog2(NUM_HEADS)  : 1;
    localparam logic [LW-1:0]        LAST_LANE  = LW'(NUM_LANES - 1);
    localparam logic [TW-1:0]        LAST_TILE  = TW'(NUM_TILES - 1);
    localparam logic [GW-1:0]        LAST_GROUP = GW'(ROW_GROUPS - 1);
    localparam logic [HW-1:0]        LAST_HEAD  = HW'(NUM_HEADS - 1);
    localparam logic [NUM_LANES-1:0] LANE0      = NUM_LANES'(1);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT, DRAIN, CLEAR, FINISH} state_t;

    state_t               state;
    logic [LW-1:0]        lane_cnt, drain_cnt;
    logic [TW-1:0]        tile_cnt;
    logic [GW-1:0]        group_cnt;
    logic [HW-1:0]        head_cnt;
    logic [NUM_LANES-1:0] sm_valid, sm_clr, r2b_valid, sm_done, done_mask;
    logic [TW-1:0]        sm_tile_idx;
    logic                 sm_en, busy, done, b2r_clr;
    logic                 accept, all_done;

    assign sm_done = bus.sm_done;

    sched_lane_done u_lane [NUM_LANES-1:0] (
        .clk  (clk),
        .rst  (rst),
        .done (sm_done),
        .clr  (sm_clr),
        .mask (done_mask)
    );

    // A mask completed by this cycle's pulses already releases WAIT.
    assign all_done = &(done_mask | sm_done);
    assign accept   = bus.b2r_valid && (state == STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lane_cnt    <= '0;
            tile_cnt    <= '0;
            group_cnt   <= '0;
            head_cnt    <= '0;
            drain_cnt   <= '0;
            sm_valid    <= '0;
            sm_tile_idx <= '0;
            sm_clr      <= '0;
            r2b_valid   <= '0;
            sm_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            b2r_clr     <= 1'b0;
        end else begin
            sm_valid    <= '0;
            sm_tile_idx <= '0;
            sm_clr      <= '0;
            done        <= 1'b0;
            b2r_clr     <= bus.b2r_slice_done && (state != IDLE);
            case (state)
                IDLE: if (bus.start) begin
                    state     <= STREAM;
                    lane_cnt  <= '0;
                    tile_cnt  <= '0;
                    group_cnt <= '0;
                    head_cnt  <= '0;
                    sm_en     <= 1'b1;
                    busy      <= 1'b1;
                end
                STREAM: if (accept) begin
                    sm_valid    <= LANE0 << lane_cnt;
                    sm_tile_idx <= tile_cnt;
                    if (lane_cnt == LAST_LANE) begin
                        lane_cnt <= '0;
                        if (tile_cnt == LAST_TILE) begin
                            tile_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            tile_cnt <= tile_cnt + 1'b1;
                        end
                    end else begin
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                WAIT: if (all_done) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                    r2b_valid <= LANE0;
                end
                DRAIN: if (bus.r2b_ready) begin
                    if (drain_cnt == LAST_LANE) begin
                        r2b_valid <= '0;
                        sm_clr    <= '1;
                        state     <= CLEAR;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        r2b_valid <= r2b_valid << 1;
                    end
                end
                CLEAR: begin
                    lane_cnt <= '0;
                    tile_cnt <= '0;
                    if (group_cnt != LAST_GROUP) begin
                        group_cnt <= group_cnt + 1'b1;
                        state     <= STREAM;
                    end else if (head_cnt != LAST_HEAD) begin
                        head_cnt  <= head_cnt + 1'b1;
                        group_cnt <= '0;
                        state     <= STREAM;
                    end else begin
                        done  <= 1'b1;
                        sm_en <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SELF_ATTN_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && bus.start)
            stall_cnt <= '0;
        else if (((state == STREAM && !bus.b2r_valid) || (state == DRAIN && !bus.r2b_ready))
                 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
    assign bus.stall_cnt = stall_cnt;
`endif

    assign bus.b2r_ready   = (state == STREAM);
    assign bus.b2r_clr     = b2r_clr;
    assign bus.sm_en       = sm_en;
    assign bus.sm_valid    = sm_valid;
    assign bus.sm_tile_idx = sm_tile_idx;
    assign bus.sm_clr      = sm_clr;
    assign bus.r2b_valid   = r2b_valid;
    assign bus.head_idx    = head_cnt;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule
